// File: rtl/exe_wb_arb.sv
// Writeback arbiter: claims finished FU result lanes, drops squashed ones and
// registers up to wbw live results per cycle for register-file write / ROB complete.
package exe_wb_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [6:0]  prd;
        logic [63:0] prdv;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;
endpackage

module exe_wb_arb
    import exe_wb_pkg::*;
#(
    parameter int nfu  = 4,
    parameter int ewd  = 2,
    parameter int wbw  = 2,
    parameter int opsz = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  red_bundle_t                         redir,
    input  exe_bundle_t [nfu-1:0][ewd-1:0]      resp,
    output logic        [nfu-1:0][ewd-1:0]      claim,
    output exe_bundle_t [wbw-1:0]               wb
);
    localparam int N  = $clog2(opsz);
    localparam int NF = (nfu > 1) ? $clog2(nfu) : 1;
    localparam int EW = (ewd > 1) ? $clog2(ewd) : 1;
    localparam int WW = (wbw > 1) ? $clog2(wbw) : 1;

    // Younger-than-redirect test, with ages taken relative to the ROB head.
    function automatic logic squash(input logic [15:0] x, input red_bundle_t r);
        logic [N-1:0] dx;
        logic [N-1:0] dr;
        dx = x[N-1:0] - r.topid[N-1:0];
        dr = r.opid[N-1:0] - r.topid[N-1:0] + N'(1);
        return r.opid[15] & x[15] & (dx >= dr);
    endfunction

    exe_bundle_t [wbw-1:0] wb_q, wb_d;
    logic [NF-1:0]         ptr_q, ptr_d;

    logic [NF-1:0] fi;
    logic          blocked;
    exe_bundle_t   lane;
    int            used;

    // Grant scan: round-robin over FUs, in-order lanes within an FU.
    always_comb begin
        claim   = '0;
        wb_d    = '0;
        ptr_d   = ptr_q;
        fi      = '0;
        blocked = 1'b0;
        lane    = '0;
        used    = 0;
        for (int s = 0; s < nfu; s++) begin
            fi      = NF'((int'(ptr_q) + s) % nfu);
            blocked = 1'b0;
            for (int j = 0; j < ewd; j++) begin
                lane = resp[fi][EW'(j)];
                if (!lane.opid[15]) begin
                    blocked = 1'b1;
                end else if (!blocked) begin
                    if (squash(lane.opid, redir)) begin
                        claim[fi][EW'(j)] = 1'b1;
                    end else if (used < wbw) begin
                        claim[fi][EW'(j)] = 1'b1;
                        wb_d[WW'(used)]   = lane;
                        used              = used + 1;
                        ptr_d             = NF'((int'(fi) + 1) % nfu);
                    end else begin
                        blocked = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            claim = '0;
        end
    end

    // Writeback register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q  <= '0;
            ptr_q <= '0;
        end else begin
            wb_q  <= wb_d;
            ptr_q <= ptr_d;
        end
    end

    // A redirect landing while a result sits in wb_q still kills it.
    always_comb begin
        wb = wb_q;
        for (int i = 0; i < wbw; i++) begin
            if (squash(wb_q[WW'(i)].opid, redir)) begin
                wb[WW'(i)].opid = '0;
            end
        end
    end
endmodule

// File: tb/tb_exe_wb_arb.sv
// Bench for exe_wb_arb: vector table with a writeback scoreboard, plus
// hand-written sequences for late squash and mid-operation reset.
module tb_exe_wb_arb;
    import exe_wb_pkg::*;

    localparam int NFU = 4;
    localparam int EWD = 2;
    localparam int WBW = 2;

    logic clk = 1'b0;
    logic rst;
    red_bundle_t                    redir;
    exe_bundle_t [NFU-1:0][EWD-1:0] resp;
    logic        [NFU-1:0][EWD-1:0] claim;
    exe_bundle_t [WBW-1:0]          wb;

    always #5 clk = ~clk;

    exe_wb_arb #(.nfu(NFU), .ewd(EWD), .wbw(WBW), .opsz(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .redir (redir),
        .resp  (resp),
        .claim (claim),
        .wb    (wb)
    );

    typedef struct packed {
        logic [7:0][15:0] ops;
        logic [15:0]      rop;
        logic [15:0]      top;
        logic [7:0]       clm;
        logic [15:0]      w0;
        logic [15:0]      w1;
    } vec_t;

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] ALL = {16'h8017, 16'h8016, 16'h8015, 16'h8014,
                                    16'h8013, 16'h8012, 16'h8011, 16'h8010};

    function automatic exe_bundle_t mk(input logic [15:0] op);
        exe_bundle_t b;
        b = '0;
        if (op[15]) begin
            b.opid = op;
            b.prd  = op[6:0];
            b.prdv = {op, ~op, 16'hA5A5, op};
        end
        return b;
    endfunction

    task automatic drive(input logic [127:0] ops, input logic [15:0] rop, input logic [15:0] top);
        logic [15:0] o;
        for (int f = 0; f < NFU; f++) begin
            for (int j = 0; j < EWD; j++) begin
                o = ops[(f*EWD+j)*16 +: 16];
                resp[f][j] = mk(o);
            end
        end
        redir.opid  = rop;
        redir.topid = top;
    endtask

    task automatic add(input logic [127:0] ops, input logic [15:0] rop, input logic [15:0] top,
                       input logic [7:0] clm, input logic [15:0] w0, input logic [15:0] w1);
        vec_t v;
        v.ops = ops; v.rop = rop; v.top = top; v.clm = clm; v.w0 = w0; v.w1 = w1;
        tbl.push_back(v);
    endtask

    task automatic chk_claim(input string nm, input logic [7:0] exp);
        checks++;
        if (claim !== exp) begin
            errors++;
            $display("FAIL %s claim=%h expected %h", nm, claim, exp);
        end
    endtask

    task automatic chk_slot(input string nm, input int idx, input logic [15:0] eop);
        exe_bundle_t act;
        logic ok;
        act = wb[idx];
        checks++;
        if (eop[15]) ok = (act === mk(eop));
        else         ok = (act.opid === 16'h0);
        if (!ok) begin
            errors++;
            $display("FAIL %s wb[%0d] opid=%h prdv=%h expected opid=%h prdv=%h",
                     nm, idx, act.opid, act.prdv, eop, mk(eop).prdv);
        end
    endtask

    task automatic chk_wb(input string nm, input exp_t e);
        chk_slot(nm, 0, e.w0);
        chk_slot(nm, 1, e.w1);
    endtask

    initial begin
        // Hold-inputs round robin, then assorted arbitration cases.
        add(ALL, 16'h0, 16'h0, 8'h03, 16'h8010, 16'h8011);
        add(ALL, 16'h0, 16'h0, 8'h0C, 16'h8012, 16'h8013);
        add(ALL, 16'h0, 16'h0, 8'h30, 16'h8014, 16'h8015);
        add(ALL, 16'h0, 16'h0, 8'hC0, 16'h8016, 16'h8017);
        add(ALL, 16'h0, 16'h0, 8'h03, 16'h8010, 16'h8011);
        add(128'h0, 16'h0, 16'h0, 8'h00, 16'h0, 16'h0);
        add({16'h0, 16'h8020, 96'h0}, 16'h0, 16'h0, 8'h40, 16'h8020, 16'h0);
        add({32'h0, 16'h8022, 16'h8021, 32'h0, 16'h0, 16'h8023}, 16'h0, 16'h0, 8'h11, 16'h8023, 16'h8021);
        add({64'h0, 16'h0, 16'h8005, 32'h0}, 16'h0, 16'h0, 8'h04, 16'h8005, 16'h0);
        add({32'h0, 16'h8009, 16'h8006, 64'h0}, 16'h8007, 16'h0003, 8'h30, 16'h8006, 16'h0);
        add(128'h0, 16'h0, 16'h0, 8'h00, 16'h0, 16'h0);
        add({16'h803D, 16'h8001, 96'h0}, 16'h803E, 16'h003C, 8'hC0, 16'h803D, 16'h0);
        add(128'h0, 16'h0, 16'h0, 8'h00, 16'h0, 16'h0);
        add({16'h8033, 16'h8032, 16'h8004, 16'h8031, 16'h8030, 16'h8003, 16'h8002, 16'h8001},
            16'h8010, 16'h0, 8'hD3, 16'h8001, 16'h8002);
        add(128'h0, 16'h0, 16'h0, 8'h00, 16'h0, 16'h0);
        add({64'h0, 16'h0, 16'h8041, 16'h0, 16'h8040}, 16'h0, 16'h0, 8'h05, 16'h8041, 16'h8040);

        rst = 1'b1;
        redir = '0;
        drive(ALL, 16'h0, 16'h0);
        repeat (2) begin
            @(negedge clk);
            chk_claim("reset_claim", 8'h00);
        end
        rst = 1'b0;
        drive(128'h0, 16'h0, 16'h0);
        #1;
        chk_wb("reset_wb", '{16'h0, 16'h0});
        chk_claim("idle_claim", 8'h00);

        foreach (tbl[k]) begin
            exp_t e;
            @(negedge clk);
            drive(tbl[k].ops, tbl[k].rop, tbl[k].top);
            #1;
            chk_claim($sformatf("vec%0d", k), tbl[k].clm);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_wb($sformatf("vec%0d_prev", k), e);
            end
            e.w0 = tbl[k].w0;
            e.w1 = tbl[k].w1;
            sb.push_back(e);
        end
        @(negedge clk);
        drive(128'h0, 16'h0, 16'h0);
        #1;
        if (sb.size() > 0) chk_wb("vec_last", sb.pop_front());

        // Redirect arriving while the result sits in the writeback register.
        @(negedge clk);
        drive({112'h0, 16'h800A}, 16'h0, 16'h0);
        #1;
        chk_claim("late_claim", 8'h01);
        @(negedge clk);
        drive(128'h0, 16'h8008, 16'h0);
        #1;
        chk_slot("late_squash", 0, 16'h0);
        drive(128'h0, 16'h0, 16'h0);
        #1;
        chk_slot("late_unsquash", 0, 16'h800A);

        // Reset in the middle of operation.
        @(negedge clk);
        drive({112'h0, 16'h8050}, 16'h0, 16'h0);
        #1;
        chk_claim("pre_rst_claim", 8'h01);
        @(negedge clk);
        rst = 1'b1;
        drive({112'h0, 16'h8051}, 16'h0, 16'h0);
        #1;
        chk_claim("rst_claim", 8'h00);
        chk_slot("rst_hold", 0, 16'h8050);
        @(negedge clk);
        #1;
        chk_wb("rst_wb", '{16'h0, 16'h0});
        rst = 1'b0;
        drive(ALL, 16'h0, 16'h0);
        #1;
        chk_claim("ptr_after_rst", 8'h03);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
